// File: rtl/frog_controller.sv
// Frog movement, lives, level and respawn controller for a 20x15 road-crossing game.
// Buttons are synchronized and edge-detected so each press moves the frog exactly once.
module frog_controller #(
    parameter int START_COL      = 10,
    parameter int START_ROW      = 14,
    parameter int MAX_COL        = 19,
    parameter int MAX_ROW        = 14,
    parameter int START_LIVES    = 3,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic       hit,
    output logic [4:0] frog_col,
    output logic [3:0] frog_row,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic       frog_visible,
    output logic       game_over
);

    localparam logic [1:0] S_PLAY = 2'd0;
    localparam logic [1:0] S_DEAD = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam logic [4:0] COL_START = 5'(START_COL);
    localparam logic [3:0] ROW_START = 4'(START_ROW);
    localparam logic [4:0] COL_MAX   = 5'(MAX_COL);
    localparam logic [3:0] ROW_MAX   = 4'(MAX_ROW);
    localparam logic [1:0] LIVES_INI = 2'(START_LIVES);
    localparam logic [7:0] RESP_CNT  = 8'(RESPAWN_FRAMES);

    logic [1:0] state_q, state_d;
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] sync3_q, sync3_d;
    logic [4:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic [1:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic [7:0] cnt_q, cnt_d;
    logic       vis_q, vis_d;
    logic       over_q, over_d;
    logic [3:0] rise;

    // Bit order {up, down, left, right}; bit 3 has the highest priority.
    assign rise = sync2_q & ~sync3_q;

    always_comb begin
        sync1_d  = {btn_up, btn_down, btn_left, btn_right};
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        lives_d  = lives_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_PLAY: begin
                if (hit) begin
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = S_OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = S_DEAD;
                        cnt_d   = 8'd0;
                    end
                end else if (rise[3]) begin
                    if (row_q == 4'd1) begin
                        if (level_q != 4'd15) level_d = level_q + 4'd1;
                        col_d = COL_START;
                        row_d = ROW_START;
                    end else if (row_q != 4'd0) begin
                        row_d = row_q - 4'd1;
                    end
                end else if (rise[2]) begin
                    if (row_q < ROW_MAX) row_d = row_q + 4'd1;
                end else if (rise[1]) begin
                    if (col_q != 5'd0) col_d = col_q - 5'd1;
                end else if (rise[0]) begin
                    if (col_q < COL_MAX) col_d = col_q + 5'd1;
                end
            end
            S_DEAD: begin
                if (frame_tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == RESP_CNT) begin
                        state_d = S_PLAY;
                        col_d   = COL_START;
                        row_d   = ROW_START;
                        cnt_d   = 8'd0;
                    end
                end
            end
            S_OVER: begin
                if (|rise) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_INI;
                    level_d = 4'd0;
                    col_d   = COL_START;
                    row_d   = ROW_START;
                end
            end
            default: begin
                state_d = S_PLAY;
            end
        endcase
        vis_d  = (state_d == S_PLAY) ||
                 ((state_d == S_DEAD) && !cnt_d[3]);
        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_PLAY;
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            sync3_q <= 4'd0;
            col_q   <= COL_START;
            row_q   <= ROW_START;
            lives_q <= LIVES_INI;
            level_q <= 4'd0;
            cnt_q   <= 8'd0;
            vis_q   <= 1'b1;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lives_q <= lives_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            vis_q   <= vis_d;
            over_q  <= over_d;
        end
    end

    assign frog_col     = col_q;
    assign frog_row     = row_q;
    assign lives        = lives_q;
    assign level        = level_q;
    assign frog_visible = vis_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_frog_controller.sv
// Directed self-checking bench for frog_controller with default parameters.
module tb_frog_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       bu, bd, bl, br;
    logic       ft, hit;
    logic [4:0] frog_col;
    logic [3:0] frog_row;
    logic [1:0] lives;
    logic [3:0] level;
    logic       frog_visible;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    frog_controller dut (
        .clk(clk), .rst(rst),
        .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
        .frame_tick(ft), .hit(hit),
        .frog_col(frog_col), .frog_row(frog_row),
        .lives(lives), .level(level),
        .frog_visible(frog_visible), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {bu, bd, bl, br, ft, hit} = 6'b0;
        step();
        step();
        rst = 1'b0;
        step();
        step();
    endtask

    // b = {up, down, left, right}; returns two edges after the capture edge.
    task automatic press(input logic [3:0] b);
        {bu, bd, bl, br} = b;
        step();
        {bu, bd, bl, br} = 4'b0;
        step();
        step();
    endtask

    task automatic ftick();
        ft = 1'b1;
        step();
        ft = 1'b0;
    endtask

    task automatic hit_pulse();
        hit = 1'b1;
        step();
        hit = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({frog_col, frog_row, lives, level, frog_visible, game_over} !==
            {5'd10, 4'd14, 2'd3, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: col=%0d row=%0d lives=%0d lvl=%0d vis=%0b go=%0b",
                     frog_col, frog_row, lives, level, frog_visible, game_over);
        end
    endtask

    task automatic test_latency();
        do_reset();
        bu = 1'b1;
        step();
        bu = 1'b0;
        checks++;
        if (frog_row !== 4'd14) begin
            errors++;
            $display("FAIL lat_edge0: row=%0d want 14", frog_row);
        end
        step();
        checks++;
        if (frog_row !== 4'd14) begin
            errors++;
            $display("FAIL lat_edge1: row=%0d want 14", frog_row);
        end
        step();
        checks++;
        if (frog_row !== 4'd13 || frog_col !== 5'd10) begin
            errors++;
            $display("FAIL lat_edge2: row=%0d col=%0d want 13/10", frog_row, frog_col);
        end
    endtask

    task automatic test_hold_and_bounds();
        do_reset();
        bl = 1'b1;
        repeat (100) step();
        bl = 1'b0;
        step();
        step();
        checks++;
        if (frog_col !== 5'd9) begin
            errors++;
            $display("FAIL hold_left: col=%0d want 9", frog_col);
        end
        repeat (9) press(4'b0010);
        repeat (10) press(4'b0010);
        checks++;
        if (frog_col !== 5'd0) begin
            errors++;
            $display("FAIL left_bound: col=%0d want 0", frog_col);
        end
        repeat (21) press(4'b0001);
        checks++;
        if (frog_col !== 5'd19) begin
            errors++;
            $display("FAIL right_bound: col=%0d want 19", frog_col);
        end
        press(4'b0100);
        checks++;
        if (frog_row !== 4'd14) begin
            errors++;
            $display("FAIL down_bound: row=%0d want 14", frog_row);
        end
        press(4'b1000);
        press(4'b0100);
        press(4'b0100);
        checks++;
        if (frog_row !== 4'd14) begin
            errors++;
            $display("FAIL down_return: row=%0d want 14", frog_row);
        end
    endtask

    task automatic test_priority();
        do_reset();
        press(4'b1001);
        checks++;
        if (frog_row !== 4'd13 || frog_col !== 5'd10) begin
            errors++;
            $display("FAIL prio_up_right: row=%0d col=%0d want 13/10", frog_row, frog_col);
        end
        press(4'b0110);
        checks++;
        if (frog_row !== 4'd14 || frog_col !== 5'd10) begin
            errors++;
            $display("FAIL prio_down_left: row=%0d col=%0d want 14/10", frog_row, frog_col);
        end
    endtask

    // Hit lands in the cycle the up edge is applied; frog must stay put.
    task automatic test_hit_and_respawn();
        do_reset();
        press(4'b0010);
        bu = 1'b1;
        step();
        bu = 1'b0;
        step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        checks++;
        if (frog_row !== 4'd14 || frog_col !== 5'd9 || lives !== 2'd2) begin
            errors++;
            $display("FAIL hit_move: row=%0d col=%0d lives=%0d want 14/9/2",
                     frog_row, frog_col, lives);
        end
        press(4'b0001);
        hit_pulse();
        checks++;
        if (frog_col !== 5'd9 || lives !== 2'd2 || frog_visible !== 1'b1) begin
            errors++;
            $display("FAIL dead_ignore: col=%0d lives=%0d vis=%0b want 9/2/1",
                     frog_col, lives, frog_visible);
        end
        for (int i = 1; i <= 59; i++) begin
            ftick();
            checks++;
            if (frog_visible !== (((i / 8) % 2) == 0)) begin
                errors++;
                $display("FAIL blink_tick%0d: vis=%0b want %0b",
                         i, frog_visible, ((i / 8) % 2) == 0);
            end
        end
        press(4'b0001);
        checks++;
        if (frog_col !== 5'd9 || frog_row !== 4'd14) begin
            errors++;
            $display("FAIL dead_59: col=%0d row=%0d want 9/14", frog_col, frog_row);
        end
        ftick();
        checks++;
        if (frog_col !== 5'd10 || frog_row !== 4'd14 || frog_visible !== 1'b1) begin
            errors++;
            $display("FAIL respawn: col=%0d row=%0d vis=%0b want 10/14/1",
                     frog_col, frog_row, frog_visible);
        end
        press(4'b0001);
        checks++;
        if (frog_col !== 5'd11) begin
            errors++;
            $display("FAIL play_after_respawn: col=%0d want 11", frog_col);
        end
    endtask

    task automatic test_game_over();
        do_reset();
        for (int h = 0; h < 2; h++) begin
            hit_pulse();
            repeat (60) ftick();
        end
        checks++;
        if (lives !== 2'd1 || game_over !== 1'b0 || frog_visible !== 1'b1) begin
            errors++;
            $display("FAIL two_hits: lives=%0d go=%0b vis=%0b want 1/0/1",
                     lives, game_over, frog_visible);
        end
        press(4'b1000);
        hit_pulse();
        checks++;
        if (lives !== 2'd0 || game_over !== 1'b1 || frog_visible !== 1'b0) begin
            errors++;
            $display("FAIL game_over: lives=%0d go=%0b vis=%0b want 0/1/0",
                     lives, game_over, frog_visible);
        end
        press(4'b0100);
        checks++;
        if (lives !== 2'd3 || level !== 4'd0 || game_over !== 1'b0 ||
            frog_visible !== 1'b1 || frog_row !== 4'd14 || frog_col !== 5'd10) begin
            errors++;
            $display("FAIL restart: lives=%0d lvl=%0d go=%0b vis=%0b row=%0d col=%0d",
                     lives, level, game_over, frog_visible, frog_row, frog_col);
        end
    endtask

    task automatic test_level();
        do_reset();
        repeat (13) press(4'b1000);
        checks++;
        if (frog_row !== 4'd1 || level !== 4'd0) begin
            errors++;
            $display("FAIL row1: row=%0d lvl=%0d want 1/0", frog_row, level);
        end
        press(4'b1000);
        checks++;
        if (level !== 4'd1 || frog_row !== 4'd14 || frog_col !== 5'd10) begin
            errors++;
            $display("FAIL cross1: lvl=%0d row=%0d col=%0d want 1/14/10",
                     level, frog_row, frog_col);
        end
        repeat (14 * 14) press(4'b1000);
        checks++;
        if (level !== 4'd15) begin
            errors++;
            $display("FAIL cross15: lvl=%0d want 15", level);
        end
        repeat (5 * 14) press(4'b1000);
        checks++;
        if (level !== 4'd15 || frog_row !== 4'd14) begin
            errors++;
            $display("FAIL cross20: lvl=%0d row=%0d want 15/14", level, frog_row);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(4'b0010);
        hit_pulse();
        repeat (10) ftick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({frog_col, frog_row, lives, level, frog_visible, game_over} !==
            {5'd10, 4'd14, 2'd3, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_dead: col=%0d row=%0d lives=%0d vis=%0b",
                     frog_col, frog_row, lives, frog_visible);
        end
        rst = 1'b0;
        step();
        repeat (3) begin
            hit_pulse();
            repeat (60) ftick();
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (game_over !== 1'b0 || lives !== 2'd3 || frog_visible !== 1'b1) begin
            errors++;
            $display("FAIL rst_over: go=%0b lives=%0d vis=%0b want 0/3/1",
                     game_over, lives, frog_visible);
        end
        br = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (frog_col !== 5'd10) begin
            errors++;
            $display("FAIL held_edge1: col=%0d want 10", frog_col);
        end
        step();
        checks++;
        if (frog_col !== 5'd11) begin
            errors++;
            $display("FAIL held_edge2: col=%0d want 11", frog_col);
        end
        repeat (10) step();
        br = 1'b0;
        checks++;
        if (frog_col !== 5'd11) begin
            errors++;
            $display("FAIL held_once: col=%0d want 11", frog_col);
        end
    endtask

    initial begin
        rst = 1'b1;
        {bu, bd, bl, br, ft, hit} = 6'b0;
        test_reset();
        test_latency();
        test_hold_and_bounds();
        test_priority();
        test_hit_and_respawn();
        test_game_over();
        test_level();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frog_controller.md
FROG_CONTROLLER -- requirements
Module: frog_controller

Interface
REQ-001 Parameter START_COL, default 10, frog spawn column (grid columns).
REQ-002 Parameter START_ROW, default 14, frog spawn row (grid rows; bottom row of the 20x15 grid).
REQ-003 Parameter MAX_COL, default 19, rightmost legal column.
REQ-004 Parameter MAX_ROW, default 14, bottom legal row.
REQ-005 Parameter START_LIVES, default 3, lives loaded at reset and restart.
REQ-006 Parameter RESPAWN_FRAMES, default 60, frame_tick pulses spent in DEAD.
REQ-007 clk  input  1  pixel clock, all logic on rising edge; one clock domain.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 btn_up, btn_down, btn_left, btn_right  input  1 each  debounced, asynchronous-to-clk buttons, active-high.
REQ-010 frame_tick  input  1  one-clk pulse per video frame.
REQ-011 hit  input  1  synchronous, high while frog cell equals any car cell.
REQ-012 frog_col  output  5  frog column.
REQ-013 frog_row  output  4  frog row.
REQ-014 lives  output  2  lives remaining.
REQ-015 level  output  4  crossings completed.
REQ-016 frog_visible  output  1  frog sprite enable.
REQ-017 game_over  output  1  high in GAMEOVER.

Function
REQ-018 Each button SHALL pass a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync3); one press = one move.
REQ-019 Latency: a button high before edge N SHALL change frog_col/frog_row at edge N+2; holding a button SHALL yield no further moves.
REQ-020 Simultaneous edges SHALL resolve by priority up > down > left > right; one move per cycle.
REQ-021 States: PLAY, DEAD, GAMEOVER, 2-bit registered.
REQ-022 PLAY: up decrements row, down increments row, left decrements col, right increments col.
REQ-023 Moves beyond bounds SHALL be ignored: no down at MAX_ROW, no left at col 0, no right at MAX_COL; no wrap-around.
REQ-024 PLAY, up at row 1 (landing row 0): SHALL increment level (saturate at 15) and place frog at START_COL/START_ROW on the same edge.
REQ-025 PLAY, hit=1: SHALL take precedence over any same-cycle move; position held; lives decrements.
REQ-026 Hit with lives>1 -> DEAD, respawn counter cleared; hit with lives==1 -> lives=0, GAMEOVER.
REQ-027 DEAD: position held at hit cell; buttons and hit ignored; counter increments per frame_tick.
REQ-028 DEAD: on the frame_tick making counter==RESPAWN_FRAMES -> PLAY, frog at START_COL/START_ROW.
REQ-029 frog_visible SHALL be 1 in PLAY, ~counter[3] in DEAD, 0 in GAMEOVER.
REQ-030 GAMEOVER: game_over=1; any button rising edge SHALL restart: lives=START_LIVES, level=0, frog at start, -> PLAY.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 rst high SHALL immediately force: state PLAY, frog_col=START_COL, frog_row=START_ROW, lives=START_LIVES, level=0, frog_visible=1, game_over=0, counter=0, synchronizer flops 0.
REQ-033 rst asserted mid-DEAD or mid-GAMEOVER SHALL yield the REQ-032 state; a button held through reset deassertion SHALL cause one move at edge 2 after release.

Verification
REQ-034 Reset, pulse btn_up one cycle-synchronous -> frog_row 14->13 at edge 2 after pin high; frog_col stays 10.
REQ-035 Hold btn_left 100 cycles -> exactly one move (col 9); 10 separate left presses from col 0 -> col remains 0.
REQ-036 btn_up and btn_right same cycle -> row decrements, col unchanged; hit and btn_up same cycle -> row unchanged, lives 3->2, state DEAD.
REQ-037 In DEAD, 59 frame_ticks -> still DEAD, frog_visible toggles every 8 ticks; 60th tick -> PLAY, frog at (10,14), visible=1.
REQ-038 Three hits (each after respawn) -> lives 0, game_over=1, frog_visible=0; btn_down press -> lives 3, level 0, PLAY.
REQ-039 14 up presses from spawn -> level 0->1, frog at (10,14); 20 crossings -> level saturates at 15.
